amt_recovery_sequencer: RTL and testbench

- Controls the architectural-map-table recovery walk after an exception or branch mis-predict.
- Triggered by the ActiveList. Waits for in-flight commits to drain, then steps through the AMT WIDTH entries per cycle. Each step drives the AMT read addresses and the RMT write enables/addresses.
- Stalls rename and commit while the walk runs and pulses done at the end.
- Sits between ActiveList, AMT read ports and RMT write ports, and replaces the free-running recover counter.

---
 rtl/amt_recovery_sequencer_pkg.sv | 27 ++
 rtl/amt_recovery_sequencer_if.sv | 32 +++
 rtl/amt_recovery_sequencer_lane_gen.sv | 32 +++
 rtl/amt_recovery_sequencer.sv | 130 +++++++++++++
 tb/tb_amt_recovery_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/amt_recovery_sequencer_pkg.sv
// Shared types and defaults for the AMT -> RMT recovery walk.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package amt_recovery_sequencer_pkg;

    // Global core sizing constants the sequencer defaults track.
    localparam int SIZE_RMT     = 34;
    localparam int SIZE_RMT_LOG = 6;
    localparam int COMMIT_WIDTH = 4;

    localparam int DEF_NUM_LOG_REGS = SIZE_RMT;
    localparam int DEF_LOG_W        = SIZE_RMT_LOG;
    localparam int DEF_WIDTH        = COMMIT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WALK  = 2'd2,
        ST_DONE  = 2'd3
    } rec_state_t;

    // Number of WIDTH-wide groups needed to cover n entries.
    function automatic int num_groups(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

endpackage

// File: rtl/amt_recovery_sequencer_if.sv
// Recovery-walk bus between ActiveList / AMT read ports / RMT write ports and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; commit_any_i must drain before the walk starts, stall_o holds the pipe.
// Ports: master = ActiveList/commit side (drives request and commit activity),
//        slave  = the sequencer (drives AMT read addresses, RMT writes and status).
interface amt_recovery_sequencer_if
    import amt_recovery_sequencer_pkg::*;
#(
    parameter int LOG_W = DEF_LOG_W,
    parameter int WIDTH = DEF_WIDTH
);
    logic                     recover_req_i;
    logic                     commit_any_i;
    logic [WIDTH*LOG_W-1:0]   amt_rd_addr_o;
    logic [WIDTH-1:0]         rmt_we_o;
    logic [WIDTH*LOG_W-1:0]   rmt_wr_addr_o;
    logic                     stall_o;
    logic                     recover_busy_o;
    logic                     recover_done_o;

    modport master (
        output recover_req_i, commit_any_i,
        input  amt_rd_addr_o, rmt_we_o, rmt_wr_addr_o,
        input  stall_o, recover_busy_o, recover_done_o
    );

    modport slave (
        input  recover_req_i, commit_any_i,
        output amt_rd_addr_o, rmt_we_o, rmt_wr_addr_o,
        output stall_o, recover_busy_o, recover_done_o
    );
endinterface

// File: rtl/amt_recovery_sequencer_lane_gen.sv
// amt_recover_lane_gen: expands a group base index into WIDTH lane addresses and a valid mask.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: base (group start index) -> addr (lane k at [k*LOG_W +: LOG_W]), mask (lane k valid iff base+k < NUM_LOG_REGS).
module amt_recover_lane_gen
    import amt_recovery_sequencer_pkg::*;
#(
    parameter int NUM_LOG_REGS = DEF_NUM_LOG_REGS,
    parameter int LOG_W        = DEF_LOG_W,
    parameter int WIDTH        = DEF_WIDTH
) (
    input  logic [LOG_W-1:0]         base,
    output logic [WIDTH*LOG_W-1:0]   addr,
    output logic [WIDTH-1:0]         mask
);

    // One extra bit so base+k past the table end compares correctly
    // instead of wrapping back into range.
    logic [LOG_W:0] lane_sum;

    always_comb begin
        addr     = '0;
        mask     = '0;
        lane_sum = '0;
        for (int k = 0; k < WIDTH; k++) begin
            lane_sum                 = {1'b0, base} + (LOG_W+1)'(k);
            addr[k*LOG_W +: LOG_W]   = lane_sum[LOG_W-1:0];
            mask[k]                  = (lane_sum < (LOG_W+1)'(NUM_LOG_REGS));
        end
    end

endmodule

// File: rtl/amt_recovery_sequencer.sv
// Sequences the AMT -> RMT restore walk after a flush: drain commits, walk WIDTH entries/cycle, pulse done.
// Latency: request (no commit) at T -> RMT writes T+1..T+ceil(N/WIDTH), done one cycle later.
// Backpressure: holds stall_o through DRAIN/WALK/DONE; repeated requests while active are absorbed.
// Ports: clk, reset (sync, active-high), bus (slave modport of amt_recovery_sequencer_if).
module amt_recovery_sequencer
    import amt_recovery_sequencer_pkg::*;
#(
    parameter int NUM_LOG_REGS = DEF_NUM_LOG_REGS,
    parameter int LOG_W        = DEF_LOG_W,
    parameter int WIDTH        = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    amt_recovery_sequencer_if.slave    bus
);

    localparam int LAST_BASE = (num_groups(NUM_LOG_REGS, WIDTH) - 1) * WIDTH;

    rec_state_t                state;
    logic [LOG_W-1:0]          base;
    logic [LOG_W:0]            base_sum;
    logic                      walk_last;
    logic [LOG_W-1:0]          gen_base;
    logic [WIDTH*LOG_W-1:0]    gen_addr;
    logic [WIDTH-1:0]          gen_mask;

    logic [WIDTH*LOG_W-1:0]    addr_q;
    logic [WIDTH-1:0]          we_q;
    logic                      stall_q;
    logic                      busy_q;
    logic                      done_q;

    // Sum kept one bit wider so the final step past the table end never wraps.
    assign base_sum  = {1'b0, base} + (LOG_W+1)'(WIDTH);
    assign walk_last = (base_sum >= (LOG_W+1)'(NUM_LOG_REGS));

    // Outputs are registered, so the lane generator looks at the base the
    // next cycle will present: the following group while walking, group 0
    // when the walk is about to start.
    assign gen_base = (state == ST_WALK) ? base_sum[LOG_W-1:0] : '0;

    amt_recover_lane_gen #(
        .NUM_LOG_REGS (NUM_LOG_REGS),
        .LOG_W        (LOG_W),
        .WIDTH        (WIDTH)
    ) u_lane_gen (
        .base (gen_base),
        .addr (gen_addr),
        .mask (gen_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            base    <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.recover_req_i) begin
                        stall_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (bus.commit_any_i) begin
                            state <= ST_DRAIN;
                        end else begin
                            state  <= ST_WALK;
                            base   <= '0;
                            addr_q <= gen_addr;
                            we_q   <= gen_mask;
                        end
                    end
                end
                // A commit sampled this cycle is still writing the AMT, so
                // the walk waits for the first commit-free cycle.
                ST_DRAIN: begin
                    if (!bus.commit_any_i) begin
                        state  <= ST_WALK;
                        base   <= '0;
                        addr_q <= gen_addr;
                        we_q   <= gen_mask;
                    end
                end
                ST_WALK: begin
                    if (walk_last) begin
                        state  <= ST_DONE;
                        we_q   <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        base   <= base_sum[LOG_W-1:0];
                        addr_q <= gen_addr;
                        we_q   <= gen_mask;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    done_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.amt_rd_addr_o  = addr_q;
    assign bus.rmt_wr_addr_o  = addr_q;
    assign bus.rmt_we_o       = we_q;
    assign bus.stall_o        = stall_q;
    assign bus.recover_busy_o = busy_q;
    assign bus.recover_done_o = done_q;

    // Commits cannot legally overlap the walk; the AMT would change under the read.
    commit_during_walk: assert property (
        @(posedge clk) disable iff (reset)
        (state == ST_WALK) |-> !bus.commit_any_i
    );

    // The walk must terminate exactly on the last group.
    walk_ends_on_last_group: assert property (
        @(posedge clk) disable iff (reset)
        (state == ST_WALK && walk_last) |-> (base == LOG_W'(LAST_BASE))
    );

endmodule

// File: tb/tb_amt_recovery_sequencer.sv
// Bench for amt_recovery_sequencer: default (34 regs) and 32-reg instances, scoreboarded outputs.
// Latency: expected write/done cycles are queued with the stimulus and matched by cycle number.
// Backpressure: n/a; monitors pop whenever a DUT shows a write or done pulse.
module tb_amt_recovery_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    amt_recovery_sequencer_if #(.LOG_W(6), .WIDTH(4)) b34 ();
    amt_recovery_sequencer_if #(.LOG_W(5), .WIDTH(4)) b32 ();

    amt_recovery_sequencer #(.NUM_LOG_REGS(34), .LOG_W(6), .WIDTH(4)) dut34 (
        .clk   (clk),
        .reset (reset),
        .bus   (b34)
    );

    amt_recovery_sequencer #(.NUM_LOG_REGS(32), .LOG_W(5), .WIDTH(4)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  we;
        logic [23:0] addr;
        logic        done;
    } exp_t;

    exp_t q34[$];
    exp_t q32[$];

    // Queue the expected walk for a request sampled at cycle t0: group g
    // writes at t0+1+g covering entries 4g..4g+3, done follows the last group.
    // limit truncates the walk (reset mid-walk), in which case no done is queued.
    task automatic push_walk(input int sel, input int t0, input int n, input int lw, input int limit);
        exp_t e;
        int   g;
        g = 0;
        while (4*g < n && g < limit) begin
            e.cyc  = t0 + 1 + g;
            e.we   = '0;
            e.addr = '0;
            e.done = 1'b0;
            for (int k = 0; k < 4; k++) begin
                e.we[k] = ((4*g + k) < n);
                e.addr  = e.addr | (24'(4*g + k) << (k*lw));
            end
            if (sel == 0) q34.push_back(e); else q32.push_back(e);
            g++;
        end
        if (4*g >= n) begin
            e.cyc  = t0 + 1 + g;
            e.we   = '0;
            e.addr = '0;
            e.done = 1'b1;
            if (sel == 0) q34.push_back(e); else q32.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_evt(input string tag, input exp_t e, input logic [3:0] we,
                             input logic [23:0] rd, input logic [23:0] wr,
                             input logic done, input logic stall, input logic busy);
        logic bad;
        bad = (cyc != e.cyc) || (we !== e.we) || (done !== e.done) || (stall !== 1'b1)
              || (busy !== (e.we != 4'b0))
              || ((e.we != 4'b0) && ((rd !== e.addr) || (wr !== e.addr)));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s got cyc=%0d we=%b rd=%h wr=%h done=%b stall=%b busy=%b exp cyc=%0d we=%b addr=%h done=%b",
                     tag, cyc, we, rd, wr, done, stall, busy, e.cyc, e.we, e.addr, e.done);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q34.size() > 0 && q34[0].cyc < cyc) begin
            e = q34.pop_front();
            checks++; errors++;
            $display("FAIL mon34_missed cyc=%0d got=nothing exp cyc=%0d we=%b done=%b", cyc, e.cyc, e.we, e.done);
        end
        if (b34.rmt_we_o != 4'b0 || b34.recover_done_o) begin
            if (q34.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon34_unexpected cyc=%0d got we=%b done=%b exp=none", cyc, b34.rmt_we_o, b34.recover_done_o);
            end else begin
                e = q34.pop_front();
                check_evt("mon34", e, b34.rmt_we_o, 24'(b34.amt_rd_addr_o), 24'(b34.rmt_wr_addr_o),
                          b34.recover_done_o, b34.stall_o, b34.recover_busy_o);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (q32.size() > 0 && q32[0].cyc < cyc) begin
            e = q32.pop_front();
            checks++; errors++;
            $display("FAIL mon32_missed cyc=%0d got=nothing exp cyc=%0d we=%b done=%b", cyc, e.cyc, e.we, e.done);
        end
        if (b32.rmt_we_o != 4'b0 || b32.recover_done_o) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon32_unexpected cyc=%0d got we=%b done=%b exp=none", cyc, b32.rmt_we_o, b32.recover_done_o);
            end else begin
                e = q32.pop_front();
                check_evt("mon32", e, b32.rmt_we_o, 24'(b32.amt_rd_addr_o), 24'(b32.rmt_wr_addr_o),
                          b32.recover_done_o, b32.stall_o, b32.recover_busy_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        reset = 1'b1;
        b34.recover_req_i = 1'b0;
        b34.commit_any_i  = 1'b0;
        b32.recover_req_i = 1'b0;
        b32.commit_any_i  = 1'b0;

        // Reset state.
        tick(); tick();
        @(negedge clk);
        chk("rst_stall", 32'(b34.stall_o), 32'd0);
        chk("rst_busy",  32'(b34.recover_busy_o), 32'd0);
        chk("rst_done",  32'(b34.recover_done_o), 32'd0);
        chk("rst_we",    32'(b34.rmt_we_o), 32'd0);
        chk("rst_addr",  32'(b34.amt_rd_addr_o), 32'd0);
        chk("rst_waddr", 32'(b34.rmt_wr_addr_o), 32'd0);
        tick();
        reset = 1'b0;

        // Idle: nothing moves.
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("idle_stall", 32'(b34.stall_o), 32'd0);
            chk("idle_we",    32'(b34.rmt_we_o), 32'd0);
        end

        // Plain request, no commit in flight.
        tick();
        t = cyc;
        b34.recover_req_i = 1'b1;
        push_walk(0, t, 34, 6, 99);
        tick();
        b34.recover_req_i = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk("walk_stall", 32'(b34.stall_o), (i <= 10) ? 32'd1 : 32'd0);
            if (i == 1) begin
                chk("first_we",   32'(b34.rmt_we_o), 32'(4'b1111));
                chk("first_addr", 32'(b34.amt_rd_addr_o), 32'({6'd3, 6'd2, 6'd1, 6'd0}));
            end
            if (i == 9) begin
                chk("last_we",   32'(b34.rmt_we_o), 32'(4'b0011));
                chk("last_addr", 32'(b34.amt_rd_addr_o), 32'({6'd35, 6'd34, 6'd33, 6'd32}));
            end
            if (i == 10) chk("done_pulse", 32'(b34.recover_done_o), 32'd1);
            tick();
        end

        // Request while commits still in flight for two cycles.
        t = cyc;
        b34.recover_req_i = 1'b1;
        b34.commit_any_i  = 1'b1;
        push_walk(0, t + 2, 34, 6, 99);
        tick();
        b34.recover_req_i = 1'b0;
        @(negedge clk);
        chk("drain_busy",  32'(b34.recover_busy_o), 32'd1);
        chk("drain_stall", 32'(b34.stall_o), 32'd1);
        chk("drain_we",    32'(b34.rmt_we_o), 32'd0);
        tick();
        b34.commit_any_i = 1'b0;
        repeat (12) tick();

        // Repeated request mid-walk is absorbed.
        t = cyc;
        b34.recover_req_i = 1'b1;
        push_walk(0, t, 34, 6, 99);
        tick();
        b34.recover_req_i = 1'b0;
        repeat (3) tick();
        b34.recover_req_i = 1'b1;
        tick();
        b34.recover_req_i = 1'b0;
        @(negedge clk);
        chk("rereq_addr", 32'(b34.amt_rd_addr_o), 32'({6'd19, 6'd18, 6'd17, 6'd16}));
        repeat (7) tick();
        chk("rereq_drained", 32'(q34.size()), 32'd0);

        // Reset mid-walk, then a fresh walk from entry 0.
        t = cyc;
        b34.recover_req_i = 1'b1;
        push_walk(0, t, 34, 6, 5);
        tick();
        b34.recover_req_i = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_we",    32'(b34.rmt_we_o), 32'd0);
        chk("midrst_stall", 32'(b34.stall_o), 32'd0);
        chk("midrst_busy",  32'(b34.recover_busy_o), 32'd0);
        chk("midrst_addr",  32'(b34.amt_rd_addr_o), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        t = cyc;
        b34.recover_req_i = 1'b1;
        push_walk(0, t, 34, 6, 99);
        tick();
        b34.recover_req_i = 1'b0;
        repeat (11) tick();

        // 32-entry instance: eight full groups.
        t = cyc;
        b32.recover_req_i = 1'b1;
        push_walk(1, t, 32, 5, 99);
        tick();
        b32.recover_req_i = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        chk("r32_last_we",   32'(b32.rmt_we_o), 32'(4'b1111));
        chk("r32_last_addr", 32'(b32.amt_rd_addr_o), 32'({5'd31, 5'd30, 5'd29, 5'd28}));
        tick();
        @(negedge clk);
        chk("r32_done", 32'(b32.recover_done_o), 32'd1);
        repeat (3) tick();

        chk("q34_empty", 32'(q34.size()), 32'd0);
        chk("q32_empty", 32'(q32.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
